compare_arbiter: RTL
====================

// Module: compare_arbiter
// PURPOSE
//  Shares the core's single Compare_Unit between two requesters: the branch resolver (BEQ..BGEU)
//  and the ALU SLT/SLTI/SLTU/SLTIU path. Arbitrates valid/ready requests, registers operands, and
//  drives the shared comparator. Decodes the branch condition and returns a registered response.
//  Sits between decode/execute and the Compare_Unit instance.
// PARAMETERS
//  XLEN     32  operand width
//  FAIR_RR  1   1: round-robin between requesters; 0: branch always has fixed priority
// PORTS
//  clk            in   1     core clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     pipeline flush; kills branch operations only
//  br_valid       in   1     branch request valid
//  br_ready       out  1     branch request accepted this cycle
//  br_a, br_b     in   XLEN  rs1/rs2 values
//  br_funct3      in   3     branch funct3
//  br_resp_valid  out  1     branch result valid
//  br_resp_taken  out  1     branch condition true
//  br_resp_illegal out 1     funct3 was 010 or 011
//  br_resp_ready  in   1     consumer accepts branch result
//  alu_valid      in   1     SLT-class request valid
//  alu_ready      out  1     SLT request accepted this cycle
//  alu_a, alu_b   in   XLEN  operands
//  alu_unsigned   in   1     1: SLTU/SLTIU, 0: SLT/SLTI
//  alu_resp_valid out  1     SLT result valid
//  alu_resp_data  out  XLEN  zero-extended 0/1 result
//  alu_resp_ready in   1     consumer accepts SLT result
//  cmp_a, cmp_b   out  XLEN  to shared Compare_Unit (registered operands)
//  cmp_signed     out  1     1 = signed compare
//  cmp_lt, cmp_eq in   1     combinational results from the Compare_Unit
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, operand regs 0, RR pointer = branch first.
//  FSM: IDLE -> EVAL -> RESP -> IDLE. One operation in flight; no overlap.
//  IDLE: when any valid, grant one: assert that requester's ready for exactly one cycle, latch
//   operands/funct3/owner -> EVAL. Both valid: FAIR_RR=1 grants the one not served last; FAIR_RR=0
//   grants branch. br_ready is held 0 while flush=1 (ALU may still be granted).
//  EVAL: cmp_* driven from regs; capture cmp_lt/cmp_eq and decoded result -> RESP.
//  RESP: owner's resp_valid=1, payload stable until resp_ready=1; on handshake -> IDLE.
//  Latency: accept in cycle N -> resp_valid in N+2; minimum 3 cycles per op; ready=0 outside IDLE.
//  Condition decode: 000 eq, 001 !eq, 100 lt(signed), 101 !lt(signed), 110 lt(unsigned),
//   111 !lt(unsigned); 010/011 -> taken=0, illegal=1. cmp_signed=~funct3[1] for branch,
//   ~alu_unsigned for ALU.
//  ALU result = {XLEN-1 zeros, cmp_lt}.
//  flush: if the owner is branch in EVAL or RESP -> IDLE immediately, no resp_valid pulse
//   (br_resp_valid drops the next cycle if it was high). ALU ops are never affected.
//  cmp_a/cmp_b hold the last values in IDLE (no toggling on idle cycles).
//  rst_n low mid-operation: immediate return to reset values; in-flight op discarded.
// CONFIGURATION
//  CMP_ARB_STATS_EN defined: adds outputs stat_br_grants, stat_alu_grants, stat_conflicts
//   (32-bit each, saturating): grant counts per requester and IDLE cycles with both valid.
//   All reset to 0 and are unaffected by flush.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  cmp_arb_pkg: FSM state enum, funct3 localparams (F3_BEQ..F3_BGEU), requester-id enum.
//  Sub-module rr_arb2: 2-way arbiter (req[1:0], fair, advance -> grant one-hot, last-served reg).
// TESTING
//  BEQ a=5,b=5 alone -> br_ready @N, br_resp_valid @N+2, taken=1, illegal=0.
//  BLT a=0xFFFFFFFF,b=1 -> taken=1; BLTU same operands -> taken=0; SLTU same -> alu_resp_data=0.
//  Both valid every cycle, FAIR_RR=1 -> grants alternate br,alu,br,...; FAIR_RR=0 -> br only.
//  Hold br_resp_ready=0 for 4 cycles -> resp_valid/taken stable, br_ready and alu_ready stay 0.
//  flush during branch EVAL -> no br_resp_valid, IDLE next cycle; flush during ALU op -> resp kept.
//  funct3=010 -> taken=0, illegal=1; rst_n pulsed in RESP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared types for compare_arbiter (FSM states, requester ids,
// branch funct3 codes and the branch-condition decoder).
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_BR  = 1'b0,
    REQ_ALU = 1'b1
  } req_id_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Returns {illegal, taken}. Signedness of lt is already applied by the
  // comparator (cmp_signed), so signed/unsigned pairs decode identically.
  function automatic logic [1:0] br_decode(input logic [2:0] f3,
                                           input logic lt, input logic eq);
    logic [1:0] r;
    r = 2'b10;
    case (f3)
      F3_BEQ:           r = {1'b0, eq};
      F3_BNE:           r = {1'b0, ~eq};
      F3_BLT, F3_BLTU:  r = {1'b0, lt};
      F3_BGE, F3_BGEU:  r = {1'b0, ~lt};
      default:          r = 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter. req[0]=branch, req[1]=ALU. With fair=1 a
// conflict goes to the requester not served last; with fair=0 branch wins.
module rr_arb2
  import cmp_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       fair,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t last;

  // One-hot grant; only a genuine conflict consults the history.
  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = (fair && last == REQ_BR) ? 2'b10 : 2'b01;
  end

  // Record who was served; reset as "ALU last" so branch goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= REQ_ALU;
    else if (advance && |grant)
      last <= grant[1] ? REQ_ALU : REQ_BR;
  end

endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: shares one Compare_Unit between the branch resolver and
// the ALU SLT path. One op in flight: IDLE (grant) -> EVAL -> RESP -> IDLE.
// Optional build macro CMP_ARB_STATS_EN adds saturating grant/conflict counters.
module compare_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FAIR_RR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [XLEN-1:0] br_a,
  input  logic [XLEN-1:0] br_b,
  input  logic [2:0]      br_funct3,
  output logic            br_resp_valid,
  output logic            br_resp_taken,
  output logic            br_resp_illegal,
  input  logic            br_resp_ready,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic            alu_unsigned,
  output logic            alu_resp_valid,
  output logic [XLEN-1:0] alu_resp_data,
  input  logic            alu_resp_ready,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic            cmp_signed,
  input  logic            cmp_lt,
  input  logic            cmp_eq
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [31:0]     stat_br_grants,
  output logic [31:0]     stat_alu_grants,
  output logic [31:0]     stat_conflicts
`endif
);

  arb_state_t state;
  req_id_t    owner;
  logic [2:0] f3_q;
  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       idle;

  assign idle = (state == ST_IDLE);

  // Requests only compete in IDLE; flush masks branch, reset masks both so
  // the readys are 0 while rst_n is low.
  assign arb_req = (idle && rst_n) ? {alu_valid, br_valid & ~flush} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .fair    (FAIR_RR != 0),
    .advance (idle),
    .grant   (grant)
  );

  assign br_ready  = grant[0];
  assign alu_ready = grant[1];

  // Operation FSM: latch operands on grant, capture the compare, hold the
  // response until the owner's consumer takes it. Flush kills branch ops only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      owner           <= REQ_BR;
      f3_q            <= '0;
      cmp_a           <= '0;
      cmp_b           <= '0;
      cmp_signed      <= 1'b0;
      br_resp_valid   <= 1'b0;
      br_resp_taken   <= 1'b0;
      br_resp_illegal <= 1'b0;
      alu_resp_valid  <= 1'b0;
      alu_resp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmp_* only change on a grant so idle cycles do not toggle them
          if (grant[0]) begin
            cmp_a      <= br_a;
            cmp_b      <= br_b;
            cmp_signed <= ~br_funct3[1];
            f3_q       <= br_funct3;
            owner      <= REQ_BR;
            state      <= ST_EVAL;
          end else if (grant[1]) begin
            cmp_a      <= alu_a;
            cmp_b      <= alu_b;
            cmp_signed <= ~alu_unsigned;
            owner      <= REQ_ALU;
            state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (owner == REQ_BR) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              {br_resp_illegal, br_resp_taken} <= br_decode(f3_q, cmp_lt, cmp_eq);
              br_resp_valid <= 1'b1;
              state         <= ST_RESP;
            end
          end else begin
            alu_resp_data  <= {{(XLEN-1){1'b0}}, cmp_lt};
            alu_resp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner == REQ_BR) begin
            if (flush || br_resp_ready) begin
              br_resp_valid <= 1'b0;
              state         <= ST_IDLE;
            end
          end else if (alu_resp_ready) begin
            alu_resp_valid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CMP_ARB_STATS_EN
  // Saturating counters; conflicts count raw valids, independent of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_grants  <= '0;
      stat_alu_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (grant[0] && stat_br_grants != '1)
        stat_br_grants <= stat_br_grants + 32'd1;
      if (grant[1] && stat_alu_grants != '1)
        stat_alu_grants <= stat_alu_grants + 32'd1;
      if (idle && br_valid && alu_valid && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
